pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//  Program-counter stage of the multicycle MIPS core; sits downstream of the control FSM.
//  Holds the PC and presents it to the memory address mux and the ALU A-input mux.
//  Captures J/BGTZ redirect requests (need_jmp, bor_j), resolves BGTZ from the ALU flag,
//  and commits the next PC (sequential or redirect) once per instruction, on the pcen rising edge.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value after reset
//  CNT_W     16             width of the redirect counter (used only with PC_TRACE_EN)
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   reset, asynchronous, active-low
//  pcen            in   1   FSM advance request; the rising edge commits the next PC
//  need_jmp        in   1   redirect request from the FSM (one-cycle pulse)
//  bor_j           in   1   redirect kind, valid with need_jmp: 1 = BGTZ, 0 = J
//  alu_gtz         in   1   ALU "rs > 0" flag; valid from the cycle after need_jmp
//  ir              in   32  current instruction register
//  pc              out  32  current PC, registered
//  pc_plus4        out  32  pc + 4, combinational, mod 2^32
//  redirect        out  1   one-cycle pulse: pc was loaded from a target
//  pending         out  1   state != S_SEQ
//  redirect_cnt    out  CNT_W  taken-redirect count; port exists only with PC_TRACE_EN
// BEHAVIOUR
//  Reset:
//   - pc = RESET_PC, state = S_SEQ, tgt = 0, redirect = 0.
//   - pcen_q = 1, so the FSM's pcen=1 held through reset does not commit.
//   - redirect_cnt = 0.
//  Commit event: commit = pcen & ~pcen_q; pcen_q <= pcen every cycle.
//   - pcen held high for several cycles gives exactly one commit.
//  Targets (32-bit, wrap mod 2^32):
//   - J:    {pc_plus4[31:28], ir[25:0], 2'b00}
//   - BGTZ: pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00}
//   - tgt is captured in the need_jmp cycle.
//  States:
//   - S_SEQ:
//     - need_jmp & ~bor_j: tgt <= J target; go to S_ARMED.
//     - need_jmp & bor_j: tgt <= BGTZ target; go to S_RESOLVE.
//     - commit: pc <= pc_plus4.
//   - S_RESOLVE: one cycle.
//     - alu_gtz = 1: go to S_ARMED; else go to S_SEQ (branch not taken).
//   - S_ARMED:
//     - commit: pc <= tgt; redirect <= 1 for one cycle; go to S_SEQ.
//  Simultaneous events:
//   - commit in S_SEQ with need_jmp: pc <= pc_plus4 and the request is still captured.
//     The redirect applies at the next commit.
//   - commit in S_RESOLVE: resolve and commit in the same edge.
//     pc <= alu_gtz ? tgt : pc_plus4; go to S_SEQ.
//   - need_jmp in S_RESOLVE or S_ARMED: ignored; the first request wins.
//  Outputs:
//   - pc changes only on a commit.
//   - redirect is 0 in every cycle except the one after a target load.
//  Reset mid-operation: any pending redirect is discarded; all outputs return to reset values.
//  pc[1:0] is not checked; it is always 2'b00 when RESET_PC is word aligned.
// CONFIGURATION
//  PC_TRACE_EN defined:
//   - redirect_cnt increments on every redirect pulse.
//   - The counter saturates at all-ones; reset clears it.
//  PC_TRACE_EN undefined: the counter logic and the redirect_cnt port are absent.
//  All other behaviour is identical in both builds.
// STRUCTURE
//  Shared package mips_pkg:
//   - state localparams S_SEQ, S_RESOLVE, S_ARMED.
//   - opcode constants OP_J = 6'h02, OP_BGTZ = 6'h07.
//   - default RESET_PC.
//  Sub-module pc_target_calc: combinational; takes (pc_plus4, ir) and produces
//  (j_tgt, b_tgt). The state register, tgt, the pc register and the counter stay in pc_next_unit.
// TESTING
//  1. Reset with pcen=1, then 3 cycles idle -> pc=0, pending=0, redirect=0; no commit.
//  2. pcen pulses 0->1 three times -> pc = 4, 8, 12.
//     pcen held high 5 cycles -> exactly one +4.
//  3. J: pc=0x0000_0010, ir=0x0800_0040, need_jmp pulse with bor_j=0, then commit
//     -> pc=0x0000_0100, redirect pulse of 1 cycle.
//  4. BGTZ: pc=0x20, ir[15:0]=0xFFFE, alu_gtz=1 -> pc=0x1C after commit.
//     Same stimulus with alu_gtz=0 -> pc=0x24, no redirect pulse.
//  5. Commit coincident with need_jmp at pc=0x40 -> pc=0x44 first.
//     The next commit loads the captured target.
//     need_jmp while S_ARMED is ignored.
//  6. Reset asserted in S_ARMED -> pc=RESET_PC, pending=0; the next commit gives RESET_PC+4.
//     PC_TRACE_EN build with CNT_W=2: 5 redirects -> redirect_cnt=3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: PC-stage states, opcodes,
// reset PC and the branch-offset helper.
package mips_pkg;

    typedef enum logic [1:0] {
        S_SEQ     = 2'd0,
        S_RESOLVE = 2'd1,
        S_ARMED   = 2'd2
    } pc_state_e;

    localparam logic [5:0]  OP_J             = 6'h02;
    localparam logic [5:0]  OP_BGTZ          = 6'h07;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sign-extended word offset of a conditional branch.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational jump/branch target generation from pc+4 and the instruction.
module pc_target_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] ir,
    output logic [31:0] j_tgt,
    output logic [31:0] b_tgt
);

    // The opcode is decoded by the control FSM; only the immediate fields matter here.
    logic unused_opcode;
    assign unused_opcode = ^ir[31:26];

    assign j_tgt = {pc_plus4[31:28], ir[25:0], 2'b00};
    assign b_tgt = pc_plus4 + br_offset(ir[15:0]);

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: captures J/BGTZ redirects and commits the next PC once
// per pcen rising edge. Define PC_TRACE_EN to add the saturating redirect_cnt port.
module pc_next_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef PC_TRACE_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcen,
    input  logic        need_jmp,
    input  logic        bor_j,
    input  logic        alu_gtz,
    input  logic [31:0] ir,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        pending
`ifdef PC_TRACE_EN
    ,
    output logic [CNT_W-1:0] redirect_cnt
`endif
);

    // Protocol: need_jmp is a one-cycle request (bor_j qualifies it) accepted only
    // in S_SEQ; pcen is level-held by the FSM and only its rising edge commits.
    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        redirect_q, redirect_d;
    logic        pcen_q;
    logic        commit;
    logic [31:0] j_tgt, b_tgt;

    assign pc_plus4 = pc_q + 32'd4;
    assign commit   = pcen & ~pcen_q;

    pc_target_calc u_target_calc (
        .pc_plus4 (pc_plus4),
        .ir       (ir),
        .j_tgt    (j_tgt),
        .b_tgt    (b_tgt)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        redirect_d = 1'b0;
        case (state_q)
            S_SEQ: begin
                // A request coinciding with a commit is still captured; it applies next commit.
                if (need_jmp) begin
                    tgt_d   = bor_j ? b_tgt : j_tgt;
                    state_d = bor_j ? S_RESOLVE : S_ARMED;
                end
                if (commit) pc_d = pc_plus4;
            end
            S_RESOLVE: begin
                if (commit) begin
                    pc_d       = alu_gtz ? tgt_q : pc_plus4;
                    redirect_d = alu_gtz;
                    state_d    = S_SEQ;
                end else begin
                    state_d = alu_gtz ? S_ARMED : S_SEQ;
                end
            end
            S_ARMED: begin
                if (commit) begin
                    pc_d       = tgt_q;
                    redirect_d = 1'b1;
                    state_d    = S_SEQ;
                end
            end
            default: state_d = S_SEQ;
        endcase
    end

    // pcen_q resets high so a pcen held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_SEQ;
            pc_q       <= RESET_PC;
            tgt_q      <= 32'd0;
            redirect_q <= 1'b0;
            pcen_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            redirect_q <= redirect_d;
            pcen_q     <= pcen;
        end
    end

    assign pc       = pc_q;
    assign redirect = redirect_q;
    assign pending  = (state_q != S_SEQ);

`ifdef PC_TRACE_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (redirect_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign redirect_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed, table-driven bench for pc_next_unit (default build; PC_TRACE_EN adds
// the redirect counter saturation sequence with CNT_W=2).
module tb_pc_next_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        pcen;
  logic        need_jmp;
  logic        bor_j;
  logic        alu_gtz;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        pending;
`ifdef PC_TRACE_EN
  logic [1:0]  redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pcen;
    logic        need_jmp;
    logic        bor_j;
    logic        alu_gtz;
    logic [31:0] ir;
    logic [31:0] exp_pc;
    logic        exp_redirect;
    logic        exp_pending;
  } vec_t;

  vec_t vecs[$];

  pc_next_unit #(
    .RESET_PC (RST_PC)
`ifdef PC_TRACE_EN
    ,
    .CNT_W    (2)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcen         (pcen),
    .need_jmp     (need_jmp),
    .bor_j        (bor_j),
    .alu_gtz      (alu_gtz),
    .ir           (ir),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .redirect     (redirect),
    .pending      (pending)
`ifdef PC_TRACE_EN
    ,
    .redirect_cnt (redirect_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver and checker tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] epc, input logic er, input logic ep);
    check({tag, " pc"}, pc, epc);
    check({tag, " pc_plus4"}, pc_plus4, epc + 32'd4);
    check({tag, " redirect"}, {31'd0, redirect}, {31'd0, er});
    check({tag, " pending"}, {31'd0, pending}, {31'd0, ep});
  endtask

  task automatic drive(input logic pe, input logic nj, input logic bj, input logic gz, input logic [31:0] ir_v);
    pcen     = pe;
    need_jmp = nj;
    bor_j    = bj;
    alu_gtz  = gz;
    ir       = ir_v;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic pe, input logic nj, input logic bj, input logic gz,
                              input logic [31:0] ir_v, input logic [31:0] epc,
                              input logic er, input logic ep);
    vec_t v;
    v.pcen = pe; v.need_jmp = nj; v.bor_j = bj; v.alu_gtz = gz; v.ir = ir_v;
    v.exp_pc = epc; v.exp_redirect = er; v.exp_pending = ep;
    return v;
  endfunction

  initial begin
    // pcen  nj  bj  gz  ir             exp_pc        red  pend
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 32'h0000_0004, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0000_0004, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 32'h0000_0008, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0000_0008, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 32'h0000_000C, 0, 0));
    // pcen held high five cycles in total: one increment only
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 32'h0000_000C, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 32'h0000_000C, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 32'h0000_000C, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 32'h0000_000C, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0000_000C, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 32'h0000_0010, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0000_0010, 0, 0));
    // J at pc=0x10, ir=0x0800_0040 -> 0x100
    vecs.push_back(mk(0, 1, 0, 0, 32'h0800_0040, 32'h0000_0010, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0000_0100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0100, 0, 0));
    // J to 0x20
    vecs.push_back(mk(0, 1, 0, 0, 32'h0800_0008, 32'h0000_0100, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0000_0020, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0020, 0, 0));
    // BGTZ taken at 0x20, offset -2 words -> 0x24 - 8 = 0x1C
    vecs.push_back(mk(0, 1, 1, 0, 32'h1C00_FFFE, 32'h0000_0020, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,         32'h0000_0020, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0000_001C, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_001C, 0, 0));
    // back to 0x20, then BGTZ not taken -> 0x24, no pulse
    vecs.push_back(mk(0, 1, 0, 0, 32'h0800_0008, 32'h0000_001C, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0000_0020, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0020, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h1C00_FFFE, 32'h0000_0020, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0020, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0000_0024, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0024, 0, 0));
    // J to 0x40, then commit coincident with a J request (target 0x100)
    vecs.push_back(mk(0, 1, 0, 0, 32'h0800_0010, 32'h0000_0024, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0000_0040, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0040, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0800_0040, 32'h0000_0044, 0, 1));
    // second request while armed (would be 0x200) is ignored
    vecs.push_back(mk(0, 1, 0, 0, 32'h0800_0080, 32'h0000_0044, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0000_0100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0100, 0, 0));
    // BGTZ at 0x100, +3 words, commit in the resolve cycle -> 0x110
    vecs.push_back(mk(0, 1, 1, 0, 32'h1C00_0003, 32'h0000_0100, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,         32'h0000_0110, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0110, 0, 0));

    // reset with pcen held high
    rst_n = 1'b0; pcen = 1'b1; need_jmp = 1'b0; bor_j = 1'b0; alu_gtz = 1'b0; ir = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("in_reset", RST_PC, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 32'h0);
      check_outs($sformatf("idle%0d", i), RST_PC, 1'b0, 1'b0);
    end

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pcen, vecs[i].need_jmp, vecs[i].bor_j, vecs[i].alu_gtz, vecs[i].ir);
      check_outs($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_redirect, vecs[i].exp_pending);
    end

    // reset while armed: redirect discarded, async clear
    drive(0, 1, 0, 0, 32'h0800_0040);
    check_outs("arm_before_rst", 32'h0000_0110, 1'b0, 1'b1);
    pcen = 1'b1; need_jmp = 1'b0; ir = 32'h0;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", RST_PC, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 32'h0);
    check_outs("post_rst_hold", RST_PC, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 32'h0);
    drive(1, 0, 0, 0, 32'h0);
    check_outs("post_rst_commit", RST_PC + 32'd4, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 32'h0);

`ifdef PC_TRACE_EN
    check("cnt_after_rst", {30'd0, redirect_cnt}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 0, 0, 32'h0800_0000);
      drive(1, 0, 0, 0, 32'h0);
      drive(0, 0, 0, 0, 32'h0);
      check($sformatf("cnt%0d", k), {30'd0, redirect_cnt}, (k > 3) ? 32'd3 : k);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
